// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade sequencer.
// Duty width default and FSM state encoding.
package pwm_pkg;

  localparam int DUTY_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

endpackage

// File: rtl/step_tick_gen.sv
// Step tick generator: one tick every STEP_CYCLES clocks while enabled.
// The counter is held at zero whenever en is low.
module step_tick_gen #(
  parameter int STEP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade envelope sequencer feeding duty_cycle of the PWM block.
// Ramp up to a latched peak, hold, ramp down, then stop or loop.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int DUTY_W      = DUTY_W_DEF,
  parameter int STEP_CYCLES = 16,
  parameter int HOLD_STEPS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [DUTY_W-1:0] target_max,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              busy,
  output logic              done
);

  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
  localparam state_t PEAK_NEXT =
    (HOLD_STEPS == 0) ? RAMP_DOWN : HOLD;

  state_t            state, state_nxt;
  logic [DUTY_W-1:0] duty_nxt;
  logic [DUTY_W-1:0] max_r, max_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic              stop_pend, pend_nxt;
  logic              done_nxt;
  logic              tick;

  assign busy = (state != IDLE);

  step_tick_gen #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (busy),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      duty_cycle <= '0;
      max_r      <= '0;
      hold_cnt   <= '0;
      stop_pend  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      duty_cycle <= duty_nxt;
      max_r      <= max_nxt;
      hold_cnt   <= hold_nxt;
      stop_pend  <= pend_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty_cycle;
    max_nxt   = max_r;
    hold_nxt  = hold_cnt;
    pend_nxt  = stop_pend;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          max_nxt = target_max;
          if (target_max == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = RAMP_UP;
          end
        end
      end
      RAMP_UP: begin
        // stop outranks a coincident tick; duty holds on that edge
        if (stop) begin
          if (duty_cycle == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = RAMP_DOWN;
            pend_nxt  = 1'b1;
          end
        end else if (tick) begin
          duty_nxt = duty_cycle + DUTY_W'(1);
          if (duty_nxt == max_r) begin
            state_nxt = PEAK_NEXT;
            hold_nxt  = '0;
          end
        end
      end
      HOLD: begin
        if (stop) begin
          state_nxt = RAMP_DOWN;
          pend_nxt  = 1'b1;
        end else if (tick) begin
          hold_nxt = hold_cnt + HW'(1);
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = RAMP_DOWN;
          end
        end
      end
      RAMP_DOWN: begin
        pend_nxt = stop_pend | stop;
        if (tick) begin
          duty_nxt = duty_cycle - DUTY_W'(1);
          if (duty_nxt == '0) begin
            done_nxt = 1'b1;
            if (loop && !pend_nxt) begin
              max_nxt   = target_max;
              state_nxt = (target_max == '0) ? IDLE : RAMP_UP;
            end else begin
              state_nxt = IDLE;
              pend_nxt  = 1'b0;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Randomized bench for pwm_fade_ctrl against a closed-form envelope model.
// Second instance covers full-scale, no-hold and async reset.
module tb_pwm_fade_ctrl;

  localparam int S = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, loop;
  logic [3:0] target_max, duty_cycle;
  logic       busy, done;

  logic       rst_nb, start_b, stop_b, loop_b;
  logic [3:0] target_b, duty_b;
  logic       busy_b, done_b;

  always #5 clk = ~clk;

  pwm_fade_ctrl #(
    .DUTY_W(4), .STEP_CYCLES(S), .HOLD_STEPS(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .loop(loop), .target_max(target_max),
    .duty_cycle(duty_cycle), .busy(busy), .done(done)
  );

  pwm_fade_ctrl #(
    .DUTY_W(4), .STEP_CYCLES(S), .HOLD_STEPS(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_nb), .start(start_b), .stop(stop_b),
    .loop(loop_b), .target_max(target_b),
    .duty_cycle(duty_b), .busy(busy_b), .done(done_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Envelope model: t0 = acceptance edge, shape from tick count j/S
  int m_busy, m_t0, m_max, m_stp, m_e, m_d, m_pend, cyc;

  function automatic int env(int j);
    int n;
    n = j / S;
    if (m_stp && j > m_e) return m_d - (n - m_e / S);
    if (m_stp) return m_d;
    if (n <= m_max) return n;
    if (n <= m_max + H) return m_max;
    return 2 * m_max + H - n;
  endfunction

  task automatic step();
    int j;
    int edone;
    bit down;
    @(posedge clk);
    cyc++;
    edone = 0;
    if (m_busy == 0) begin
      if (start && !stop) begin
        m_max = int'(target_max);
        if (m_max == 0) begin
          edone = 1;
        end else begin
          m_busy = 1; m_t0 = cyc; m_stp = 0; m_pend = 0;
        end
      end
    end else begin
      j = cyc - m_t0;
      down = (m_stp != 0) || ((j - 1) / S >= m_max + H);
      if (stop && !down) begin
        m_d = env(j - 1);
        m_stp = 1; m_e = j; m_pend = 1;
        if (m_d == 0) begin
          m_busy = 0; edone = 1;
        end
      end else begin
        if (stop) m_pend = 1;
        if (down && env(j) == 0) begin
          edone = 1;
          if (loop && m_pend == 0) begin
            m_max = int'(target_max);
            m_t0 = cyc; m_stp = 0;
            if (m_max == 0) m_busy = 0;
          end else begin
            m_busy = 0;
          end
        end
      end
    end
    #1;
    chk("busy", int'(busy), m_busy);
    chk("duty", int'(duty_cycle), (m_busy != 0) ? env(cyc - m_t0) : 0);
    chk("done", int'(done), edone);
  endtask

  task automatic wait_idle(int lim);
    int k;
    k = 0;
    while (busy && k < lim) begin
      step();
      k++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int bl, dc, pk, c;
    bit hit;
    rst_n = 0; start = 0; stop = 0; loop = 0; target_max = 0;
    rst_nb = 0; start_b = 0; stop_b = 0; loop_b = 0; target_b = 0;
    m_busy = 0; m_t0 = 0; m_max = 0; m_stp = 0;
    m_e = 0; m_d = 0; m_pend = 0; cyc = 0;
    #2;
    chk("rst_duty", int'(duty_cycle), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    #10;
    rst_n = 1; rst_nb = 1;

    // basic envelope, peak 3
    step();
    target_max = 3; start = 1;
    step();
    start = 0;
    bl = int'(busy); dc = int'(done); pk = int'(duty_cycle);
    for (int k = 0; k < 40; k++) begin
      step();
      bl += int'(busy); dc += int'(done);
      if (int'(duty_cycle) > pk) pk = int'(duty_cycle);
    end
    chk("s1_busy_len", bl, 32);
    chk("s1_done_cnt", dc, 1);
    chk("s1_peak", pk, 3);

    // zero target
    target_max = 0; start = 1;
    step();
    start = 0;
    chk("s2_busy", int'(busy), 0);
    chk("s2_done", int'(done), 1);
    step();

    // graceful stop at duty 2
    target_max = 7; start = 1;
    step();
    start = 0;
    c = 0;
    while (duty_cycle != 4'd2 && c < 100) begin
      step();
      c++;
    end
    chk("s3_reach2", int'(duty_cycle), 2);
    stop = 1;
    step();
    stop = 0;
    chk("s3_hold", int'(duty_cycle), 2);
    wait_idle(100);

    // loop, retarget, then stop
    loop = 1; target_max = 2; start = 1;
    step();
    start = 0;
    dc = 0;
    for (int k = 0; k < 48; k++) begin
      step();
      dc += int'(done);
    end
    chk("s4_loop_done", dc, 2);
    target_max = 4;
    pk = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (int'(duty_cycle) > pk) pk = int'(duty_cycle);
    end
    chk("s4_peak", pk, 4);
    stop = 1;
    step();
    stop = 0;
    wait_idle(100);
    loop = 0;
    step();

    // ignored starts while busy, start+stop in idle
    target_max = 5; start = 1;
    step();
    pk = 0;
    for (int k = 0; k < 60; k++) begin
      start = (k % 7 == 0);
      target_max = 4'd9;
      step();
      if (int'(duty_cycle) > pk) pk = int'(duty_cycle);
    end
    start = 0;
    wait_idle(100);
    chk("s5_peak", pk, 5);
    target_max = 6; start = 1; stop = 1;
    step();
    start = 0; stop = 0;
    chk("s5_startstop", int'(busy), 0);

    // randomized traffic
    for (int k = 0; k < 2500; k++) begin
      start = ($urandom_range(0, 9) == 0);
      stop = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) loop = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) target_max = 4'($urandom_range(0, 15));
      step();
    end
    start = 0; stop = 0; loop = 0;
    wait_idle(300);

    // full scale, no hold
    target_b = 15; start_b = 1;
    step();
    start_b = 0;
    pk = 0; c = 0; hit = 0;
    while (!hit && c < 200) begin
      step();
      c++;
      if (int'(duty_b) > pk) pk = int'(duty_b);
      hit = done_b;
    end
    chk("s6_len", c, 120);
    chk("s6_peak", pk, 15);
    chk("s6_end_busy", int'(busy_b), 0);
    chk("s6_end_duty", int'(duty_b), 0);

    // async reset mid ramp-down
    start_b = 1;
    step();
    start_b = 0;
    c = 0; hit = 0;
    while (!(hit && duty_b == 4'd10) && c < 200) begin
      step();
      c++;
      if (duty_b == 4'd15) hit = 1;
    end
    chk("s6_reach10", int'(duty_b), 10);
    #1;
    rst_nb = 0;
    #1;
    chk("s6_rst_duty", int'(duty_b), 0);
    chk("s6_rst_busy", int'(busy_b), 0);
    chk("s6_rst_done", int'(done_b), 0);
    #2;
    rst_nb = 1;
    dc = 0; bl = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      dc += int'(done_b);
      bl += int'(busy_b);
    end
    chk("s6_no_done", dc, 0);
    chk("s6_stay_idle", bl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
Sequencer that drives the duty_cycle input of the team's 4-bit PWM block to produce a fade (breathing) envelope.
- Envelope: ramp up from 0 to a latched maximum, hold, ramp down to 0, then stop or loop.
- All duty changes occur on an internal step tick, so the PWM sees one step per programmable interval.
- Sits between the control logic (buttons/regs) and the PWM instance.

Parameters:
DUTY_W, 4, width of duty_cycle; must match the PWM block.
STEP_CYCLES, 16, clk cycles per step tick (>=1).
HOLD_STEPS, 4, step ticks spent at maximum duty (0 = no hold).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to begin an envelope; ignored while busy.
stop  in  1  one-cycle request for a graceful stop.
loop  in  1  level; when 1 at the end of a ramp-down, restart the envelope.
target_max  in  DUTY_W  peak duty; latched on start acceptance and on each loop restart.
duty_cycle  out  DUTY_W  registered duty to the PWM block.
busy  out  1  high whenever the state is not IDLE.
done  out  1  one-cycle pulse when an envelope ends (duty back at 0).

Behaviour:
Interface decided: one clock (clk); reset is asynchronous and active-low (rst_n).

Reset values:
- state=IDLE; duty_cycle=0; busy=0; done=0.
- max_r=0; tick counter=0; hold counter=0; stop_pend=0.

Tick generator:
- Counter runs 0..STEP_CYCLES-1 only while busy; tick=1 when count==STEP_CYCLES-1.
- Counter is cleared in IDLE, so the first tick is the STEP_CYCLES-th edge after start acceptance.

States: IDLE, RAMP_UP, HOLD, RAMP_DOWN.

IDLE:
- start=1 and stop=0: latch max_r=target_max.
  - If target_max==0: pulse done next cycle and remain in IDLE.
  - Otherwise go to RAMP_UP, busy=1.
- start=1 and stop=1 together: stop wins; no action.

RAMP_UP:
- On tick: duty+=1.
- If the new duty==max_r: go to HOLD (or to RAMP_DOWN if HOLD_STEPS==0), hold counter cleared.

HOLD:
- On tick: hold counter +1.
- On the tick where the hold counter reaches HOLD_STEPS-1: go to RAMP_DOWN.
- duty_cycle does not change in HOLD.

RAMP_DOWN:
- On tick: duty-=1.
- When the new duty==0:
  - done=1 for that cycle.
  - If loop=1 and stop_pend=0: relatch max_r=target_max. If the new max_r==0, go to IDLE; otherwise stay busy and go to RAMP_UP.
  - Else: go to IDLE, busy=0, stop_pend cleared.

stop while busy:
- Sets stop_pend.
- In RAMP_UP or HOLD: go to RAMP_DOWN on the next edge. The tick counter is not cleared; ramp-down continues from the current duty.
- If duty==0 at that moment (RAMP_UP before its first tick): go straight to IDLE with a done pulse.
- stop in RAMP_DOWN only suppresses the loop restart.
- stop in IDLE is ignored.

Other rules:
- start while busy is ignored; it is not queued.
- duty_cycle never exceeds max_r and never wraps. Arithmetic is unsigned DUTY_W bits; max_r==2^DUTY_W-1 is legal.
- Envelope length with no stop: (2*max_r + HOLD_STEPS) * STEP_CYCLES cycles from acceptance to the done pulse.
- rst_n low mid-envelope: all outputs return to reset values immediately (asynchronously), with no done pulse.
- target_max and loop are sampled only at the points above; changes at other times have no effect.

Decomposition:
Shared package pwm_pkg:
- DUTY_W default.
- State encoding constants: IDLE=2'd0, RAMP_UP=2'd1, HOLD=2'd2, RAMP_DOWN=2'd3.

One sub-module, step_tick_gen, parameterised by STEP_CYCLES:
- Inputs: clk, rst_n, en.
- Output: tick.
- Counter clears when en=0.

The FSM and duty register live in pwm_fade_ctrl.

Test Plan:
All scenarios use STEP_CYCLES=4 and HOLD_STEPS=2 unless noted.
1. Basic envelope: start pulse, target_max=3, loop=0.
   - duty follows 0,1,2,3 (hold 8 cycles),2,1,0, changing every 4 cycles.
   - busy high for 32 cycles; a single done pulse as duty returns to 0.
2. Zero target: start with target_max=0.
   - busy stays 0, duty stays 0, done pulses once one cycle after start.
3. Graceful stop: start with target_max=7; stop when duty=2 during RAMP_UP.
   - Next transition goes to RAMP_DOWN; duty goes 2 to 1 to 0 on subsequent ticks; then done pulses and busy drops.
4. Loop then stop: loop=1, target_max=2.
   - Envelopes repeat back-to-back with a done pulse at each duty==0.
   - Change target_max to 4 mid-envelope: the next envelope peaks at 4.
   - Assert stop: the current ramp-down completes, then IDLE.
5. Ignored requests:
   - start pulses while busy cause no restart and no max_r change.
   - start and stop together in IDLE leave busy=0.
6. Async reset and full scale (HOLD_STEPS=0, target_max=15):
   - Peak duty reaches 15 with no wrap; envelope is 120 cycles.
   - rst_n low for 3 ns mid-RAMP_DOWN forces duty=0 and busy=0 immediately, with no done pulse.
